// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and issues one memory request at a time.
// It holds each returned instruction in a one-entry valid/ready buffer for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_sel,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] req_pc_q;
    logic        drop_q;
    logic        if_valid_q;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            if (if_ready) begin
                if_valid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (!if_valid_q || if_ready) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        req_pc_q <= fetch_pc_q;
                        drop_q   <= pc_sel;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        // A same-cycle redirect makes this response stale, just like a pending drop.
                        if (!drop_q && !pc_sel) begin
                            if_instr_q <= imem_rdata;
                            if_pc_q    <= req_pc_q;
                            if_valid_q <= 1'b1;
                        end
                        drop_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (pc_sel) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if ((state_q == REQ && imem_gnt) || pc_sel) begin
                fetch_pc_q <= pc;
            end

            // Redirect flushes the buffer last so it wins over a same-cycle load.
            if (pc_sel) begin
                if_valid_q <= 1'b0;
            end
        end
    end

    assign pc_next   = fetch_pc_q + PC_STEP;
    assign imem_req  = (state_q == REQ);
    assign imem_addr = fetch_pc_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, decode stall, redirects, PC wrap, reset mid-request.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_sel;
    logic [31:0] jmp_addr;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    logic        gnt_en;
    logic        resp_en;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pc_sel     (pc_sel),
        .pc_next    (pc_next),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // PC mux and a memory that answers one cycle after a grant (held off while resp_en=0).
    assign pc          = pc_sel ? jmp_addr : pc_next;
    assign imem_gnt    = gnt_en;
    assign imem_rvalid = pend && resp_en;
    assign imem_rdata  = instr_of(pend_addr);

    always @(posedge clk) begin
        if (imem_req && imem_gnt) begin
            pend      <= 1'b1;
            pend_addr <= imem_addr;
        end else if (imem_rvalid) begin
            pend <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b0;
        pc_sel   = 1'b0;
        jmp_addr = '0;
        gnt_en   = 1'b1;
        resp_en  = 1'b1;
        if_ready = 1'b1;

        step();
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc_next", pc_next, 32'h4);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);

        reset = 1'b1;
        step();
        chk("seq_req0", {31'd0, imem_req}, 32'd1);
        chk("seq_addr0", imem_addr, 32'h0);
        step();
        chk("seq_wait_req", {31'd0, imem_req}, 32'd0);
        chk("seq_addr_adv", imem_addr, 32'h4);
        chk("seq_pc_next", pc_next, 32'h8);
        step();
        chk("seq_valid0", {31'd0, if_valid}, 32'd1);
        chk("seq_if_pc0", if_pc, 32'h0);
        chk("seq_instr0", if_instr, instr_of(32'h0));
        step();
        chk("seq_req1", {31'd0, imem_req}, 32'd1);
        chk("seq_addr1", imem_addr, 32'h4);
        chk("seq_drained", {31'd0, if_valid}, 32'd0);
        step();
        step();
        chk("seq_if_pc1", if_pc, 32'h4);
        chk("seq_instr1", if_instr, instr_of(32'h4));
        step();
        chk("seq_addr2", imem_addr, 32'h8);
        step();
        step();
        chk("seq_valid2", {31'd0, if_valid}, 32'd1);
        chk("seq_if_pc2", if_pc, 32'h8);
        chk("seq_instr2", if_instr, instr_of(32'h8));

        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_if_pc", if_pc, 32'h8);
            chk("stall_instr", if_instr, instr_of(32'h8));
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        if_ready = 1'b1;
        step();
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'hC);
        chk("resume_valid", {31'd0, if_valid}, 32'd0);

        resp_en = 1'b0;
        step();
        chk("rw_wait_req", {31'd0, imem_req}, 32'd0);
        pc_sel   = 1'b1;
        jmp_addr = 32'h100;
        step();
        pc_sel  = 1'b0;
        resp_en = 1'b1;
        chk("rw_target", imem_addr, 32'h100);
        chk("rw_valid", {31'd0, if_valid}, 32'd0);
        step();
        chk("rw_dropped", {31'd0, if_valid}, 32'd0);
        step();
        chk("rw_req", {31'd0, imem_req}, 32'd1);
        chk("rw_addr", imem_addr, 32'h100);
        step();
        step();
        chk("rw_valid_t", {31'd0, if_valid}, 32'd1);
        chk("rw_if_pc", if_pc, 32'h100);
        chk("rw_instr", if_instr, instr_of(32'h100));

        step();
        chk("rg_req", {31'd0, imem_req}, 32'd1);
        chk("rg_addr_stale", imem_addr, 32'h104);
        pc_sel   = 1'b1;
        jmp_addr = 32'h100;
        step();
        pc_sel = 1'b0;
        chk("rg_wait_req", {31'd0, imem_req}, 32'd0);
        chk("rg_target", imem_addr, 32'h100);
        step();
        chk("rg_dropped", {31'd0, if_valid}, 32'd0);
        step();
        chk("rg_req2", {31'd0, imem_req}, 32'd1);
        chk("rg_addr2", imem_addr, 32'h100);
        step();
        step();
        chk("rg_valid", {31'd0, if_valid}, 32'd1);
        chk("rg_if_pc", if_pc, 32'h100);

        step();
        chk("wr_req", {31'd0, imem_req}, 32'd1);
        pc_sel   = 1'b1;
        jmp_addr = 32'hFFFF_FFFC;
        step();
        pc_sel = 1'b0;
        chk("wr_pc_next", pc_next, 32'h0000_0000);
        chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        step();
        chk("wr_req_top", {31'd0, imem_req}, 32'd1);
        chk("wr_addr_top2", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wr_addr_wrap", imem_addr, 32'h0);
        step();
        chk("wr_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("wr_instr", if_instr, instr_of(32'hFFFF_FFFC));
        step();
        chk("wr_req0", {31'd0, imem_req}, 32'd1);
        chk("wr_addr0", imem_addr, 32'h0);

        step();
        resp_en = 1'b0;
        reset   = 1'b0;
        step();
        chk("rs_valid", {31'd0, if_valid}, 32'd0);
        chk("rs_req", {31'd0, imem_req}, 32'd0);
        chk("rs_addr", imem_addr, 32'h0);
        reset   = 1'b1;
        resp_en = 1'b1;
        step();
        chk("rs_ignored", {31'd0, if_valid}, 32'd0);
        chk("rs_req_again", {31'd0, imem_req}, 32'd1);
        chk("rs_addr_again", imem_addr, 32'h0);
        step();
        step();
        chk("rs_valid_new", {31'd0, if_valid}, 32'd1);
        chk("rs_if_pc_new", if_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits around the PC mux.
- Holds the architectural fetch PC register and drives pc_next = PC+4 into the mux.
- Samples the mux output pc to advance, or to redirect when the mux selects the jump address.
- Fetches one instruction at a time over a req/gnt/rvalid memory port and presents it to decode through a one-entry valid/ready buffer.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC value loaded on reset.
- PC_STEP, 4, byte increment used to form pc_next.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; reset=0 at a rising clk edge resets the block.
- pc  in  32  PC selected by the PC mux: pc_next, or jmp_addr when pc_sel=1.
- pc_sel  in  1  redirect indication, also driven to the PC mux; 1 = taken jump/branch.
- pc_next  out  32  fetch_pc + PC_STEP to the PC mux; purely a function of the register, no path from pc.
- imem_req  out  1  instruction memory request valid.
- imem_addr  out  32  request address = fetch_pc.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid for the single outstanding request.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  buffered instruction available to decode.
- if_ready  in  1  decode accepts the instruction this cycle.
- if_instr  out  32  buffered instruction.
- if_pc  out  32  address of if_instr.

Behaviour:
- State: fetch_pc[31:0], req_pc[31:0], drop, out buffer (if_valid/if_instr/if_pc), FSM {IDLE, REQ, WAIT}.
- Reset (reset=0): state=IDLE, fetch_pc=RESET_PC, req_pc=0, drop=0, if_valid=0, if_instr=0, if_pc=0, imem_req=0.
  - pc_next = RESET_PC+PC_STEP.
  - A response arriving after reset is ignored.
  - Reset overrides every other event in the same cycle.
- imem_req=1 only in REQ; imem_addr=fetch_pc always.
- pc_next = fetch_pc + PC_STEP, truncated to 32 bits (0xFFFF_FFFC wraps to 0x0000_0000).
- IDLE -> REQ when (!if_valid || if_ready). Otherwise stay in IDLE.
- REQ, imem_gnt=1: req_pc<=fetch_pc; fetch_pc<=pc; go to WAIT.
- REQ, no gnt: stay in REQ. imem_addr may change only on a redirect; memory must tolerate an address change while ungranted.
- WAIT, imem_rvalid=1 and drop=0: if_instr<=imem_rdata, if_pc<=req_pc, if_valid<=1; go to IDLE.
  - The buffer is guaranteed empty at this point (single outstanding request, issued only when the buffer was free or draining).
- WAIT, imem_rvalid=1 and drop=1: discard the data, clear drop, go to IDLE.
- Out buffer: if_valid clears on if_ready=1 unless reloaded in the same cycle. if_instr/if_pc hold while if_valid=1 and if_ready=0.
- Redirect (pc_sel=1, any state):
  - fetch_pc<=pc, i.e. the jump target.
  - if_valid<=0, which overrides a same-cycle load; an if_ready handshake in the same cycle still completes.
  - In REQ with gnt in the same cycle: the granted stale request sets drop=1 and the FSM goes to WAIT.
  - In WAIT without rvalid: drop<=1.
  - In WAIT with rvalid in the same cycle: the response is discarded and the FSM goes to IDLE with drop=0.
  - In REQ without gnt: stay in REQ; the next cycle requests the target.
- Latency: with imem_gnt in the first REQ cycle, rvalid one cycle later, and if_ready=1, one instruction every 3 cycles. The first if_valid appears 3 cycles after reset deasserts.
- At most one outstanding memory request at all times.

Test Plan:
- Reset release, RESET_PC=0, gnt immediate, rvalid at +1, if_ready=1 -> imem_addr sequence 0,4,8; if_pc 0,4,8 with if_instr = rdata; pc_next=4 right after reset.
- Decode stall, if_ready=0 for 5 cycles with if_valid=1 -> if_instr/if_pc stable; imem_req stays 0; fetching resumes the cycle after if_ready=1.
- Redirect while in WAIT, pc_sel=1 with pc=0x100 -> the old response is dropped (if_valid stays 0); next imem_addr=0x100, then if_pc=0x100.
- Redirect in the same cycle as imem_gnt -> the granted response is discarded; the following request is 0x100.
- Wrap: fetch_pc=0xFFFF_FFFC -> pc_next=0x0000_0000; the next fetch address is 0.
- Reset asserted in WAIT, then rvalid arrives -> data ignored, if_valid=0, imem_addr=RESET_PC.
